// File: rtl/instr_fetch_pkg.sv
// Shared constants and types for the PIC10F20x instruction-fetch slice.
// Optional FETCH_FLUSH_CNT_EN adds a squashed-slot counter to instr_fetch.
package instr_fetch_pkg;

  localparam int PIC_INSTR_WIDTH        = 12;
  localparam int L2_PIC_INSTR_MEM_DEPTH = 9;
  localparam int STACK_DEPTH            = 2;

  typedef logic [L2_PIC_INSTR_MEM_DEPTH-1:0] pc_t;
  typedef logic [PIC_INSTR_WIDTH-1:0]        instr_t;

  localparam pc_t    RESET_VECTOR = 9'h1FF;
  localparam pc_t    PC_ONE       = 9'h001;
  localparam instr_t INSTR_NOP    = 12'h000;

  typedef enum logic {
    S_FILL = 1'b0,
    S_RUN  = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/instr_fetch_call_stack.sv
// Hardware return stack: push shifts down, pop shifts up.
// Overflow drops the oldest entry; underflow repeats the bottom entry.
module instr_fetch_call_stack
  import instr_fetch_pkg::*;
#(
  parameter int DEPTH = STACK_DEPTH
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              push,
  input  logic                              pop,
  input  logic [L2_PIC_INSTR_MEM_DEPTH-1:0] din,
  output logic [L2_PIC_INSTR_MEM_DEPTH-1:0] top
);

  pc_t stk [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++)
        stk[i] <= '0;
    end else if (push) begin
      stk[0] <= din;
      for (int i = 1; i < DEPTH; i++)
        stk[i] <= stk[i-1];
    end else if (pop) begin
      for (int i = 0; i < DEPTH - 1; i++)
        stk[i] <= stk[i+1];
    end
  end

  assign top = stk[0];

endmodule

// File: rtl/instr_fetch.sv
// PC / fetch stage with 1-slot redirect squash and return stack.
// Define FETCH_FLUSH_CNT_EN to expose a saturating flush_count output.
module instr_fetch
  import instr_fetch_pkg::*;
(
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              en,
  output logic [L2_PIC_INSTR_MEM_DEPTH-1:0] imem_addr,
  input  logic [PIC_INSTR_WIDTH-1:0]        imem_rdata,
  output logic [PIC_INSTR_WIDTH-1:0]        instruction,
  output logic                              instr_valid,
  output logic [L2_PIC_INSTR_MEM_DEPTH-1:0] instr_addr,
  input  logic                              goto_enable,
  input  logic [L2_PIC_INSTR_MEM_DEPTH-1:0] goto_addr,
  input  logic                              call_enable,
  input  logic [L2_PIC_INSTR_MEM_DEPTH-1:0] call_addr,
  input  logic                              ret_enable,
  input  logic                              skip_req
`ifdef FETCH_FLUSH_CNT_EN
  ,
  output logic [15:0]                       flush_count
`endif
);

  fetch_state_e state, state_nxt;

  pc_t    pc;
  pc_t    stk_top;
  instr_t hold_instr;
  logic   stall_q;
  logic   run;
  logic   live;
  logic   push;
  logic   pop;
  logic   squash;

  always_ff @(posedge clk) begin
    if (rst)
      state <= S_FILL;
    else if (en)
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    run       = 1'b0;
    unique case (state)
      S_FILL: state_nxt = S_RUN;
      S_RUN:  run = 1'b1;
      default: state_nxt = S_FILL;
    endcase
  end

  always_comb begin
    live   = en & run;
    push   = live & call_enable;
    pop    = live & ret_enable & ~call_enable;
    squash = live & (goto_enable | call_enable |
                     ret_enable | skip_req);

    imem_addr = pc;
    if (push)
      imem_addr = call_addr;
    else if (pop)
      imem_addr = stk_top;
    else if (live & goto_enable)
      imem_addr = goto_addr;

    instr_valid = run & ~squash;
    instruction = INSTR_NOP;
    if (instr_valid)
      instruction = stall_q ? hold_instr : imem_rdata;
  end

  // Memory keeps clocking during a stall, so the presented word is
  // captured on the first stalled edge and replayed until en returns.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc         <= RESET_VECTOR;
      instr_addr <= '0;
      stall_q    <= 1'b0;
      hold_instr <= INSTR_NOP;
    end else begin
      stall_q <= ~en;
      if (en) begin
        pc         <= imem_addr + PC_ONE;
        instr_addr <= imem_addr;
      end else if (!stall_q) begin
        hold_instr <= imem_rdata;
      end
    end
  end

  instr_fetch_call_stack #(
    .DEPTH (STACK_DEPTH)
  ) u_stack (
    .clk  (clk),
    .rst  (rst),
    .push (push),
    .pop  (pop),
    .din  (instr_addr),
    .top  (stk_top)
  );

`ifdef FETCH_FLUSH_CNT_EN
  always_ff @(posedge clk) begin
    if (rst)
      flush_count <= '0;
    else if (squash && flush_count != 16'hFFFF)
      flush_count <= flush_count + 16'd1;
  end
`endif

  always_ff @(posedge clk) begin
    if (!rst && live)
      assert ($countones({goto_enable, call_enable, ret_enable}) < 2)
        else $error("instr_fetch: multiple redirect pulses");
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Scoreboard bench for instr_fetch: slot-sequence model with queue stack,
// directed scenarios followed by randomized redirects, stalls and resets.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [8:0]  imem_addr;
  logic [11:0] imem_rdata;
  logic [11:0] instruction;
  logic        instr_valid;
  logic [8:0]  instr_addr;
  logic        goto_enable;
  logic [8:0]  goto_addr;
  logic        call_enable;
  logic [8:0]  call_addr;
  logic        ret_enable;
  logic        skip_req;
`ifdef FETCH_FLUSH_CNT_EN
  logic [15:0] flush_count;
`endif

  instr_fetch dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .imem_addr   (imem_addr),
    .imem_rdata  (imem_rdata),
    .instruction (instruction),
    .instr_valid (instr_valid),
    .instr_addr  (instr_addr),
    .goto_enable (goto_enable),
    .goto_addr   (goto_addr),
    .call_enable (call_enable),
    .call_addr   (call_addr),
    .ret_enable  (ret_enable),
    .skip_req    (skip_req)
`ifdef FETCH_FLUSH_CNT_EN
    ,
    .flush_count (flush_count)
`endif
  );

  always #5 clk = ~clk;

  logic [11:0] mem [512];

  always @(posedge clk) imem_rdata <= mem[imem_addr];

  typedef struct {
    bit          chk;
    logic        v;
    logic [8:0]  a;
    logic [11:0] i;
    logic [15:0] fc;
  } exp_t;

  exp_t       scb [$];
  int         n_pass = 0;
  int         n_total = 0;

  // Reference model: slot sequence, not pipeline registers.
  bit         m_fill;
  logic [8:0] m_cur;
  logic [8:0] m_nxt;
  logic [8:0] m_stk [$];
  int         m_fc;
  bit         m_last_ok;

  task automatic check(input string nm, input logic [15:0] act,
                       input logic [15:0] req);
    n_total++;
    if (act === req)
      n_pass++;
    else
      $display("FAIL %s: got %h expected %h at %0t", nm, act, req, $time);
  endtask

  task automatic step(input bit e, input bit r, input bit g,
                      input logic [8:0] ga, input bit c,
                      input logic [8:0] ca, input bit rt, input bit sk);
    exp_t x;
    bit   sq;
    @(negedge clk);
    en = e; rst = r;
    goto_enable = g; goto_addr = ga;
    call_enable = c; call_addr = ca;
    ret_enable = rt; skip_req = sk;
    sq = !m_fill && e && (g || c || rt || sk);
    x.chk = !r;
    x.a   = m_cur;
    x.fc  = 16'(m_fc);
    x.v   = !m_fill && !sq;
    x.i   = x.v ? mem[m_cur] : 12'h000;
    scb.push_back(x);
    m_last_ok = e && !r && x.v;
    if (r) begin
      m_fill = 1; m_cur = 9'h000; m_nxt = 9'h1FF;
      m_stk = '{9'h000, 9'h000}; m_fc = 0;
    end else if (e) begin
      if (m_fill) begin
        m_fill = 0;
        m_cur = m_nxt;
      end else begin
        if (sq && m_fc < 65535) m_fc++;
        if (c) begin
          m_stk.push_front(m_cur);
          if (m_stk.size() > 2) void'(m_stk.pop_back());
          m_cur = ca;
        end else if (rt) begin
          m_cur = m_stk[0];
          if (m_stk.size() > 1) void'(m_stk.pop_front());
        end else if (g) begin
          m_cur = ga;
        end else begin
          m_cur = m_nxt;
        end
      end
      m_nxt = m_cur + 9'd1;
    end
  endtask

  task automatic plain();        step(1,0,0,0,0,0,0,0); endtask
  task automatic stall();        step(0,0,0,0,0,0,0,0); endtask
  task automatic go(input logic [8:0] a);   step(1,0,1,a,0,0,0,0); endtask
  task automatic call(input logic [8:0] a); step(1,0,0,0,1,a,0,0); endtask
  task automatic ret();          step(1,0,0,0,0,0,1,0); endtask
  task automatic skip();         step(1,0,0,0,0,0,0,1); endtask
  task automatic run_to(input logic [8:0] a);
    for (int k = 0; k < 16 && m_cur != a; k++) plain();
  endtask

  exp_t mx;
  always @(negedge clk) begin
    #2;
    if (scb.size() > 0) begin
      mx = scb.pop_front();
      if (mx.chk) begin
        check("instr_valid", 16'(instr_valid), 16'(mx.v));
        check("instr_addr", 16'(instr_addr), 16'(mx.a));
        check("instruction", 16'(instruction), 16'(mx.i));
`ifdef FETCH_FLUSH_CNT_EN
        check("flush_count", flush_count, mx.fc);
`endif
      end
    end
  end

  initial begin
    int  kind;
    bit  e, r;
    en = 0; rst = 1;
    goto_enable = 0; goto_addr = 0;
    call_enable = 0; call_addr = 0;
    ret_enable = 0; skip_req = 0;
    m_fill = 1; m_cur = 0; m_nxt = 9'h1FF;
    m_stk = '{9'h000, 9'h000}; m_fc = 0; m_last_ok = 0;
    for (int i = 0; i < 512; i++) mem[i] = 12'($urandom);
    mem[9'h1FF] = 12'hC05;
    mem[9'h000] = 12'h000;

    step(1,1,0,0,0,0,0,0);
    step(1,1,0,0,0,0,0,0);
    plain(); plain(); plain(); plain();

    go(9'h010); plain(); go(9'h040); plain();

    go(9'h020); plain(); call(9'h080); plain();
    run_to(9'h085); ret(); plain(); plain();

    go(9'h100); plain();
    call(9'h110); plain(); call(9'h120); plain();
    call(9'h130); plain();
    ret(); plain(); ret(); plain(); ret(); plain();

    go(9'h030); plain(); skip(); plain(); plain();

    stall(); stall(); stall(); plain(); plain();
    go(9'h050); stall(); stall(); plain(); plain();
    step(1,1,1,9'h0A0,0,0,0,0);
    plain(); plain(); plain();

    for (int n = 0; n < 3000; n++) begin
      e = ($urandom_range(0, 9) != 0);
      r = ($urandom_range(0, 399) == 0);
      kind = (e && m_last_ok) ? int'($urandom_range(0, 11)) : 0;
      step(e, r, kind == 1, 9'($urandom_range(0, 511)),
           kind == 2, 9'($urandom_range(0, 511)),
           kind == 3, kind == 4);
    end
    plain();

    repeat (3) @(negedge clk);
    #4;
    check("scoreboard_drained", 16'(scb.size()), 16'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
